fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants: FSM state enum, redirect modes, default bubble word.
package fetch_pkg;

  // Fetch control states; RUN and STEP may request, HALT only drains returns.
  typedef enum logic [1:0] {
    FS_RUN  = 2'd0,
    FS_HALT = 2'd1,
    FS_STEP = 2'd2
  } fetch_state_e;

  // redir_mode encodings.
  localparam logic REDIR_REL = 1'b0;
  localparam logic REDIR_ABS = 1'b1;

  // Bubble encoding presented on out_window when no window is available.
  localparam int unsigned DEFAULT_NOP_WORD = 1;

  // Width of the debug step counter.
  localparam int unsigned STEP_CNT_W = 6;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular buffer of {PC, word} with a two-entry read window.
// Push and pop may happen together even when full; clr empties it at once.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           push,
  input  logic [PC_W-1:0]                push_pc,
  input  logic [IW-1:0]                  push_word,
  input  logic                           pop,
  output logic [PC_W-1:0]                head_pc,
  output logic [IW-1:0]                  head_word,
  output logic [IW-1:0]                  next_word,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   nxt_ptr;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [IW-1:0]   word_mem [DEPTH];

  // Status, read window and pointer/count updates.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    count     = count_q;
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    nxt_ptr   = rd_ptr_q + AW'(1);
    head_pc   = pc_mem[rd_ptr_q];
    head_word = word_mem[rd_ptr_q];
    next_word = word_mem[nxt_ptr];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      word_mem[wr_ptr_q] <= push_word;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, byte-reverses returned
// words into a prefetch buffer and presents overlapping two-word windows.
// Supports relative/absolute redirect, flush/replay and debug halt.
// Build option: define FETCH_DEBUG_STEP_EN to enable the counted STEP state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     IW       = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [IW-1:0]   NOP_WORD = IW'(DEFAULT_NOP_WORD)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [IW-1:0]         imem_data,
  input  logic                  redir_valid,
  input  logic                  redir_mode,
  input  logic [PC_W-1:0]       redir_base,
  input  logic [PC_W-1:0]       redir_off,
  input  logic [PC_W-1:0]       redir_target,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IW-1:0]       out_window,
  output logic [PC_W-1:0]       out_pc,
  input  logic                  dbg_stop,
  input  logic                  dbg_continue,
  input  logic                  dbg_step_en,
  input  logic [5:0]            dbg_step_count,
  output logic                  halted
);

  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned OW     = CW + 1;
  localparam int unsigned NBYTES = IW / 8;

  localparam logic [1:0] ST_RUN  = 2'(FS_RUN);
  localparam logic [1:0] ST_HALT = 2'(FS_HALT);
  localparam logic [1:0] ST_STEP = 2'(FS_STEP);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] head_pc_q, head_pc_d;
  logic            epoch_q, epoch_d;
  logic            infl_q, infl_d;
  logic            infl_epoch_q, infl_epoch_d;

  logic [PC_W-1:0] f_head_pc;
  logic [IW-1:0]   f_head_word;
  logic [IW-1:0]   f_next_word;
  logic            f_full;
  logic            f_empty;
  logic [CW-1:0]   f_count;

  logic [OW-1:0]   occ_c;
  logic [IW-1:0]   word_rev;
  logic [PC_W-1:0] redir_tgt;
  logic            hs;
  logic            discard;
  logic            ret_ok;
  logic            push;

`ifdef FETCH_DEBUG_STEP_EN
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
`else
  logic unused_step;
  assign unused_step = ^{dbg_step_en, dbg_step_count};
`endif

  // Outputs decoded from state; a request is only made when its return is guaranteed room.
  always_comb begin
    occ_c      = OW'(f_count) + OW'(infl_q);
    imem_req   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && (occ_c < OW'(DEPTH));
    imem_addr  = pc_q;
    halted     = (state_q == ST_HALT);
    out_valid  = (state_q != ST_HALT) && (f_count >= CW'(2));
    out_pc     = f_empty ? head_pc_q : f_head_pc;
    out_window = {NOP_WORD, NOP_WORD};
    if (out_valid) out_window = {f_head_word, f_next_word};
  end

  // Memory returns words with reversed byte order.
  always_comb begin
    word_rev = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      word_rev[b*8 +: 8] = imem_data[(NBYTES-1-b)*8 +: 8];
    end
  end

  // Redirect target selection.
  always_comb begin
    redir_tgt = redir_target;
    case (redir_mode)
      REDIR_REL: redir_tgt = redir_base + redir_off;
      REDIR_ABS: redir_tgt = redir_target;
      default:   redir_tgt = redir_target;
    endcase
  end

  // Handshake, discard and push qualification; stale-epoch returns are dropped.
  always_comb begin
    hs      = out_valid && out_ready;
    discard = redir_valid || flush;
    ret_ok  = infl_q && (infl_epoch_q == epoch_q);
    push    = ret_ok && !discard && (!f_full || hs);
  end

  // PC, head PC, epoch and in-flight tracking; a handshake is applied before any discard.
  always_comb begin
    pc_d         = pc_q;
    head_pc_d    = head_pc_q;
    epoch_d      = epoch_q;
    infl_d       = imem_req;
    infl_epoch_d = epoch_q;
    if (imem_req) pc_d = pc_q + PC_W'(1);
    if (hs)       head_pc_d = head_pc_q + PC_W'(1);
    if (redir_valid) begin
      pc_d      = redir_tgt;
      head_pc_d = redir_tgt;
    end else if (flush) begin
      pc_d = head_pc_d;
    end
    if (discard) epoch_d = ~epoch_q;
  end

  // Debug FSM next state; priority stop > continue > step.
  always_comb begin
    state_d = state_q;
`ifdef FETCH_DEBUG_STEP_EN
    step_cnt_d = step_cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (dbg_stop) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!dbg_stop) begin
          if (dbg_continue) begin
            state_d = ST_RUN;
          end
`ifdef FETCH_DEBUG_STEP_EN
          else if (dbg_step_en && (dbg_step_count != '0)) begin
            state_d    = ST_STEP;
            step_cnt_d = dbg_step_count;
          end
`endif
        end
      end
      ST_STEP: begin
`ifdef FETCH_DEBUG_STEP_EN
        if (dbg_stop) begin
          state_d = ST_HALT;
        end else if (hs) begin
          step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
          if (step_cnt_q == STEP_CNT_W'(1)) state_d = ST_HALT;
        end
`else
        state_d = ST_HALT;
`endif
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_HALT;
      pc_q         <= RESET_PC;
      head_pc_q    <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_epoch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_pc_q    <= head_pc_d;
      epoch_q      <= epoch_d;
      infl_q       <= infl_d;
      infl_epoch_q <= infl_epoch_d;
    end
  end

`ifdef FETCH_DEBUG_STEP_EN
  // Remaining handshakes permitted in STEP.
  always_ff @(posedge clock) begin
    if (!reset) step_cnt_q <= '0;
    else        step_cnt_q <= step_cnt_d;
  end
`endif

  fetch_fifo #(
    .PC_W  (PC_W),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .clr       (discard),
    .push      (push),
    .push_pc   (head_pc_q + PC_W'(f_count)),
    .push_word (word_rev),
    .pop       (hs),
    .head_pc   (f_head_pc),
    .head_word (f_head_word),
    .next_word (f_next_word),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

endmodule
